writeback_stage: RTL

//  WB stage directly upstream of the register file; its outputs drive rd_wb, write_data_register_wb and regwrite_wb.
//  - Three result sources:
//    - single-cycle ALU
//    - one outstanding variable-latency load (completion via data_ready_mem)
//    - multi-cycle FPU
//  - Picks one write per cycle, sign/zero-extends load data and registers the result.
//  - Exports pending-load info for ID hazard logic.

---
 rtl/writeback_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates load/ALU/FPU results into one registered register-file write.
// Optional perf counters are enabled by defining WB_PERF_EN.
module writeback_stage #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int FZERO_IDX = 30
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [1:0]        alu_regwrite,
   input  logic [DATA_W-1:0] alu_result,
   output logic              alu_ready,
   input  logic              ld_issue,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [1:0]        ld_regwrite,
   input  logic [2:0]        ld_funct3,
   input  logic [1:0]        ld_addr_lo,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              data_ready_mem,
   input  logic              fpu_valid,
   input  logic [REG_AW-1:0] fpu_rd,
   input  logic [1:0]        fpu_regwrite,
   input  logic [DATA_W-1:0] fpu_result,
   output logic              fpu_ready,
   output logic              ld_pending,
   output logic [REG_AW-1:0] ld_pending_rd,
   output logic [1:0]        ld_pending_file,
   output logic [REG_AW-1:0] rd_wb,
   output logic [DATA_W-1:0] write_data_register_wb,
   output logic [1:0]        regwrite_wb,
   output logic [31:0]       wb_count,
   output logic [31:0]       fpu_stall_count
);
   localparam logic [REG_AW-1:0] FZERO = REG_AW'(FZERO_IDX);

   typedef enum logic {IDLE, WAIT} ld_state_e;

   ld_state_e         state_q, state_d;
   logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
   logic [1:0]        ld_file_q, ld_file_d;
   logic [2:0]        ld_funct3_q, ld_funct3_d;
   logic [1:0]        ld_addr_q, ld_addr_d;
   logic [REG_AW-1:0] rd_wb_q, rd_wb_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        regwrite_wb_q, regwrite_wb_d;

   logic              load_done;
   logic              ld_capture;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] ld_data;
   logic              win_valid, win_en;
   logic [REG_AW-1:0] win_rd;
   logic [1:0]        win_code;
   logic [DATA_W-1:0] win_data;

   // A data_ready_mem arriving while reset is asserted must not retire the load.
   assign load_done  = rstn && (state_q == WAIT) && data_ready_mem;
   assign ld_capture = ld_issue && ((state_q == IDLE) || data_ready_mem);

   always_comb begin
      state_d     = state_q;
      ld_rd_d     = ld_rd_q;
      ld_file_d   = ld_file_q;
      ld_funct3_d = ld_funct3_q;
      ld_addr_d   = ld_addr_q;
      if (state_q == IDLE) begin
         if (ld_issue) state_d = WAIT;
      end else if (data_ready_mem && !ld_issue) begin
         state_d = IDLE;
      end
      if (ld_capture) begin
         ld_rd_d     = ld_rd;
         ld_file_d   = ld_regwrite;
         ld_funct3_d = ld_funct3;
         ld_addr_d   = ld_addr_lo;
      end
   end

   always_comb begin
      byte_sel = mem_rdata[8*ld_addr_q +: 8];
      half_sel = mem_rdata[16*ld_addr_q[1] +: 16];
      case (ld_funct3_q)
         3'b000:  ld_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         3'b001:  ld_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         3'b100:  ld_data = {{(DATA_W-8){1'b0}}, byte_sel};
         3'b101:  ld_data = {{(DATA_W-16){1'b0}}, half_sel};
         default: ld_data = mem_rdata;
      endcase
      if (ld_file_q == 2'b10) ld_data = mem_rdata;
   end

   assign alu_ready = rstn && !load_done;
   assign fpu_ready = rstn && !load_done && !alu_valid;

   always_comb begin
      win_valid = 1'b0;
      win_rd    = '0;
      win_code  = 2'b00;
      win_data  = '0;
      if (load_done) begin
         win_valid = 1'b1;
         win_rd    = ld_rd_q;
         win_code  = ld_file_q;
         win_data  = ld_data;
      end else if (alu_valid && alu_ready) begin
         win_valid = 1'b1;
         win_rd    = alu_rd;
         win_code  = alu_regwrite;
         win_data  = alu_result;
      end else if (fpu_valid && fpu_ready) begin
         win_valid = 1'b1;
         win_rd    = fpu_rd;
         win_code  = fpu_regwrite;
         win_data  = fpu_result;
      end
      // Writes to hardwired-zero registers and code 11 are consumed silently.
      win_en = win_valid && (((win_code == 2'b01) && (win_rd != '0)) ||
                             ((win_code == 2'b10) && (win_rd != FZERO)));
      regwrite_wb_d = win_en ? win_code : 2'b00;
      rd_wb_d       = win_en ? win_rd   : rd_wb_q;
      wdata_d       = win_en ? win_data : wdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= IDLE;
         ld_rd_q       <= '0;
         ld_file_q     <= 2'b00;
         ld_funct3_q   <= 3'b000;
         ld_addr_q     <= 2'b00;
         rd_wb_q       <= '0;
         wdata_q       <= '0;
         regwrite_wb_q <= 2'b00;
      end else begin
         state_q       <= state_d;
         ld_rd_q       <= ld_rd_d;
         ld_file_q     <= ld_file_d;
         ld_funct3_q   <= ld_funct3_d;
         ld_addr_q     <= ld_addr_d;
         rd_wb_q       <= rd_wb_d;
         wdata_q       <= wdata_d;
         regwrite_wb_q <= regwrite_wb_d;
      end
   end

   assign ld_pending             = (state_q == WAIT);
   assign ld_pending_rd          = ld_rd_q;
   assign ld_pending_file        = ld_file_q;
   assign rd_wb                  = rd_wb_q;
   assign write_data_register_wb = wdata_q;
   assign regwrite_wb            = regwrite_wb_q;

`ifdef WB_PERF_EN
   logic [31:0] wb_count_q, wb_count_d;
   logic [31:0] fpu_stall_q, fpu_stall_d;

   always_comb begin
      wb_count_d  = wb_count_q + {31'd0, regwrite_wb_q != 2'b00};
      fpu_stall_d = fpu_stall_q + {31'd0, fpu_valid && !fpu_ready};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wb_count_q  <= 32'd0;
         fpu_stall_q <= 32'd0;
      end else begin
         wb_count_q  <= wb_count_d;
         fpu_stall_q <= fpu_stall_d;
      end
   end

   assign wb_count        = wb_count_q;
   assign fpu_stall_count = fpu_stall_q;
`else
   assign wb_count        = 32'd0;
   assign fpu_stall_count = 32'd0;
`endif

endmodule
